// File: rtl/sparse_mult_pkg.sv
// Shared types and constants for the sparse multiplication pass sequencer.
package sparse_mult_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_DONE
  } state_t;

  // Galois polynomial x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit Galois LFSR with seed load; an all-zero seed falls back to the default state.
module lfsr16_galois
  import sparse_mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  // State register: load has priority over step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_DEFAULT;
    end else if (load) begin
      state <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/dummy_slot_scheduler.sv
// Issues MAX_WEIGHT equally-timed op slots per pass: WEIGHT real positions read
// from the position RAM, interleaved with LFSR-placed dummy ops.
module dummy_slot_scheduler
  import sparse_mult_pkg::*;
#(
  parameter int MAX_WEIGHT     = 75,
  parameter int WEIGHT         = 66,
  parameter int N              = 17669,
  parameter int POS_WIDTH      = 16,
  parameter int LOGN           = $clog2(N),
  parameter int LOG_WEIGHT     = $clog2(WEIGHT),
  parameter int LOG_MAX_WEIGHT = $clog2(MAX_WEIGHT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [15:0]               seed_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      ram_rd_en_o,
  output logic [LOG_WEIGHT-1:0]     ram_addr_o,
  input  logic [POS_WIDTH-1:0]      ram_q_i,
  output logic                      op_valid_o,
  input  logic                      op_ready_i,
  output logic [POS_WIDTH-1:0]      op_pos_o,
  output logic                      op_dummy_o,
  output logic [LOG_MAX_WEIGHT-1:0] op_slot_o
);

  localparam logic [LOG_MAX_WEIGHT:0] DUMMIES = (LOG_MAX_WEIGHT+1)'(MAX_WEIGHT - WEIGHT);
  localparam logic [LOG_WEIGHT:0]     RIDX_END = (LOG_WEIGHT+1)'(WEIGHT);
  localparam logic [31:0]             LMASK    = 32'((1 << LOGN) - 1);

  state_t                    state, state_nx;
  logic [LOG_MAX_WEIGHT-1:0] slot;
  logic [LOG_WEIGHT:0]       ridx;
  logic [LOG_MAX_WEIGHT:0]   dcnt;
  logic                      is_dummy;
  logic [15:0]               lfsr, lsnap;
  logic                      lfsr_load, lfsr_step;
  logic                      take_dummy, last_slot, busy_r;
  logic [POS_WIDTH-1:0]      op_pos_r;
  logic                      op_dummy_r;
  logic [31:0]               lval, lred;

  lfsr16_galois u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed_i),
    .state (lfsr)
  );

  // Slot decisions, dummy position reduction and LFSR control.
  always_comb begin
    take_dummy = (dcnt != '0) && ((ridx == RIDX_END) || lfsr[0]);
    last_slot  = (slot == LOG_MAX_WEIGHT'(MAX_WEIGHT - 1));
    lfsr_load  = (state == S_IDLE) && start_i;
    lfsr_step  = (state == S_FETCH);
    lval       = {16'h0000, lsnap} & LMASK;
    lred       = (lval >= 32'(N)) ? (lval - 32'(N)) : lval;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nx    = state;
    ram_rd_en_o = 1'b0;
    ram_addr_o  = '0;
    op_valid_o  = 1'b0;
    done_o      = 1'b0;
    unique case (state)
      S_IDLE:  if (start_i) state_nx = S_FETCH;
      S_FETCH: begin
        ram_rd_en_o = 1'b1;
        ram_addr_o  = (ridx >= RIDX_END) ? LOG_WEIGHT'(WEIGHT - 1) : ridx[LOG_WEIGHT-1:0];
        state_nx    = S_WAIT;
      end
      S_WAIT:  state_nx = S_ISSUE;
      S_ISSUE: begin
        op_valid_o = 1'b1;
        if (op_ready_i) state_nx = last_slot ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done_o   = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Counters and op registers; the dummy decision and LFSR bits are captured in
  // FETCH so WAIT works from the pre-advance LFSR value.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r     <= 1'b0;
      slot       <= '0;
      ridx       <= '0;
      dcnt       <= '0;
      is_dummy   <= 1'b0;
      lsnap      <= '0;
      op_pos_r   <= '0;
      op_dummy_r <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (start_i) begin
          busy_r <= 1'b1;
          slot   <= '0;
          ridx   <= '0;
          dcnt   <= DUMMIES;
        end
        S_FETCH: begin
          is_dummy <= take_dummy;
          lsnap    <= lfsr;
        end
        S_WAIT: begin
          op_dummy_r <= is_dummy;
          if (is_dummy) begin
            op_pos_r <= POS_WIDTH'(lred);
            dcnt     <= dcnt - 1'b1;
          end else begin
            op_pos_r <= ram_q_i;
            ridx     <= ridx + 1'b1;
          end
        end
        S_ISSUE: if (op_ready_i) slot <= last_slot ? '0 : slot + 1'b1;
        S_DONE:  busy_r <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy_o     = busy_r;
  assign op_pos_o   = op_pos_r;
  assign op_dummy_o = op_dummy_r;
  assign op_slot_o  = slot;

endmodule

// File: tb/tb_dummy_slot_scheduler.sv
// Bench for dummy_slot_scheduler: an 8/5 build (main) and a 5/5 build (no dummies),
// checked against a slot-list reference model and a per-pass vector table.
module tb_dummy_slot_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] seed;
  logic        ready;

  // DUT A: MAX_WEIGHT=8, WEIGHT=5
  logic        a_busy, a_done, a_rd_en, a_valid, a_dummy;
  logic [2:0]  a_addr, a_slot;
  logic [15:0] a_q, a_pos;
  // DUT B: MAX_WEIGHT=WEIGHT=5
  logic        b_busy, b_done, b_rd_en, b_valid, b_dummy;
  logic [2:0]  b_addr, b_slot;
  logic [15:0] b_q, b_pos;

  logic [15:0] mem [0:7];
  logic        sel;

  always #5 clk = ~clk;

  dummy_slot_scheduler #(.MAX_WEIGHT(8), .WEIGHT(5), .N(100), .POS_WIDTH(16)) u_a (
    .clk(clk), .rst(rst), .start_i(start), .seed_i(seed), .busy_o(a_busy), .done_o(a_done),
    .ram_rd_en_o(a_rd_en), .ram_addr_o(a_addr), .ram_q_i(a_q), .op_valid_o(a_valid),
    .op_ready_i(ready), .op_pos_o(a_pos), .op_dummy_o(a_dummy), .op_slot_o(a_slot));

  dummy_slot_scheduler #(.MAX_WEIGHT(5), .WEIGHT(5), .N(100), .POS_WIDTH(16)) u_b (
    .clk(clk), .rst(rst), .start_i(start), .seed_i(seed), .busy_o(b_busy), .done_o(b_done),
    .ram_rd_en_o(b_rd_en), .ram_addr_o(b_addr), .ram_q_i(b_q), .op_valid_o(b_valid),
    .op_ready_i(ready), .op_pos_o(b_pos), .op_dummy_o(b_dummy), .op_slot_o(b_slot));

  // Position RAMs with one cycle read latency.
  always @(posedge clk) begin
    if (a_rd_en) a_q <= mem[a_addr];
    if (b_rd_en) b_q <= mem[b_addr];
  end

  // Observed signals of the DUT under test.
  logic        c_busy, c_done, c_rd_en, c_valid, c_dummy;
  logic [2:0]  c_addr, c_slot;
  logic [15:0] c_pos;
  assign c_busy  = sel ? b_busy  : a_busy;
  assign c_done  = sel ? b_done  : a_done;
  assign c_rd_en = sel ? b_rd_en : a_rd_en;
  assign c_valid = sel ? b_valid : a_valid;
  assign c_dummy = sel ? b_dummy : a_dummy;
  assign c_addr  = sel ? b_addr  : a_addr;
  assign c_slot  = sel ? b_slot  : a_slot;
  assign c_pos   = sel ? b_pos   : a_pos;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: the ordered list of slots a pass must issue.
  logic [15:0] exp_pos  [0:7];
  logic        exp_dum  [0:7];
  int          exp_addr [0:7];

  task automatic build_model(input logic [15:0] s, input int m, input int w);
    logic [15:0] l;
    int r, d;
    l = (s == 16'h0000) ? 16'hACE1 : s;
    r = 0;
    d = m - w;
    for (int k = 0; k < m; k++) begin
      exp_addr[k] = (r < w) ? r : w - 1;
      exp_dum[k]  = (d > 0) && (r == w || l[0]);
      if (exp_dum[k]) begin
        exp_pos[k] = 16'((int'(l) % 128) % 100);
        d--;
      end else begin
        exp_pos[k] = mem[r];
        r++;
      end
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    end
  endtask

  logic [15:0] got_pos [0:7];
  logic        got_dum [0:7];

  // One pass: start, optional stall in one slot, optional ignored re-start,
  // optional random back-pressure; checks every observed cycle.
  task automatic run_pass(input logic [15:0] s, input int st_slot, input int st_len,
                          input int rs_slot, input int rnd, input int exp_len);
    int m, cyc, nops, ndone, done_cyc, nrd, stalls, st_left, ndum;
    m = sel ? 5 : 8;
    build_model(s, m, 5);
    nops = 0; ndone = 0; done_cyc = -1; nrd = 0; stalls = 0; st_left = st_len; ndum = 0;
    @(negedge clk);
    start = 1'b1; seed = s; ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc < 600 && !(done_cyc >= 0 && cyc > done_cyc + 1)) begin
      start = 1'b0;
      ready = 1'b1;
      if (cyc == 1) chk("busy_after_start", 32'(c_busy), 1);
      if (done_cyc >= 0 && cyc == done_cyc + 1) chk("busy_after_done", 32'(c_busy), 0);
      if (c_rd_en) begin
        if (nrd < m) chk("ram_addr", 32'(c_addr), exp_addr[nrd]);
        nrd++;
      end
      if (c_done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (c_valid) begin
        if (int'(c_slot) == st_slot && st_left > 0) begin
          ready = 1'b0;
          st_left--;
        end else if (rnd != 0) begin
          ready = 1'($urandom_range(0, 1));
        end
        if (int'(c_slot) == rs_slot) begin
          start = 1'b1;
          seed  = 16'h5A5A;
        end
        if (!ready) stalls++;
        if (nops < m) begin
          chk("op_slot", 32'(c_slot), nops);
          chk("op_pos", 32'(c_pos), 32'(exp_pos[nops]));
          chk("op_dummy", 32'(c_dummy), 32'(exp_dum[nops]));
        end
        if (ready) begin
          if (nops < m) begin
            got_pos[nops] = c_pos;
            got_dum[nops] = c_dummy;
          end
          ndum += int'(c_dummy);
          nops++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    ready = 1'b1;
    chk("handshakes", nops, m);
    chk("dummy_count", ndum, m - 5);
    chk("rd_en_pulses", nrd, m);
    chk("done_pulses", ndone, 1);
    chk("pass_length", done_cyc, 3 * m + 1 + stalls);
    if (exp_len > 0) chk("pass_length_tbl", done_cyc, exp_len);
  endtask

  typedef struct {
    logic [15:0] seed;
    int st_slot;
    int st_len;
    int rs_slot;
    int rnd;
    int exp_len;
  } vec_t;

  vec_t        tbl [0:7];
  logic [15:0] row_pos [0:7][0:7];
  logic        row_dum [0:7][0:7];

  initial begin
    tbl[0] = '{16'h0001, -1, 0, -1, 0, 25};
    tbl[1] = '{16'h0001, -1, 0, -1, 0, 25};
    tbl[2] = '{16'h0000, -1, 0, -1, 0, 25};
    tbl[3] = '{16'hACE1, -1, 0, -1, 0, 25};
    tbl[4] = '{16'h0001,  2, 10, -1, 0, 35};
    tbl[5] = '{16'h3C5A, -1, 0,  4, 0, 25};
    tbl[6] = '{16'($urandom), -1, 0, -1, 1, 0};
    tbl[7] = '{16'($urandom), -1, 0, -1, 1, 0};

    for (int i = 0; i < 8; i++) mem[i] = (i < 5) ? 16'(10 * (i + 1)) : 16'h0000;
    sel = 1'b0; start = 1'b0; seed = '0; ready = 1'b1; rst = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_rd_en", 32'(a_rd_en), 0);
    chk("rst_pos", 32'(a_pos), 0);
    chk("rst_slot", 32'(a_slot), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_pass(tbl[i].seed, tbl[i].st_slot, tbl[i].st_len, tbl[i].rs_slot, tbl[i].rnd, tbl[i].exp_len);
      for (int k = 0; k < 8; k++) begin
        row_pos[i][k] = got_pos[k];
        row_dum[i][k] = got_dum[k];
      end
      repeat (2) @(negedge clk);
    end

    // Repeatability: same seed twice, and seed 0 equal to the default seed.
    for (int k = 0; k < 8; k++) begin
      chk("repeat_pos", 32'(row_pos[1][k]), 32'(row_pos[0][k]));
      chk("repeat_dum", 32'(row_dum[1][k]), 32'(row_dum[0][k]));
      chk("seed0_pos", 32'(row_pos[3][k]), 32'(row_pos[2][k]));
    end

    // Reset during WAIT of slot 3 aborts the pass with no done pulse.
    @(negedge clk);
    start = 1'b1; seed = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_slot", 32'(a_slot), 3);
    chk("pre_rst_wait", 32'({a_rd_en, a_valid, a_busy}), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_outputs", 32'({a_busy, a_done, a_rd_en, a_valid, a_dummy, a_addr, a_slot, a_pos}), 0);
    for (int k = 0; k < 6; k++) begin
      chk("post_rst_idle", 32'({a_busy, a_done, a_valid, a_rd_en}), 0);
      @(negedge clk);
    end
    run_pass(16'h0001, -1, 0, -1, 0, 25);

    // No-dummy build.
    repeat (30) @(negedge clk);
    sel = 1'b1;
    run_pass(16'h0001, -1, 0, -1, 0, 16);
    repeat (2) @(negedge clk);
    run_pass(16'($urandom), -1, 0, -1, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
